// File: rtl/dma_bypass_reg_master_pkg.sv
// bypass_reg_pkg: shared types and constants for the bypass-register master.
//   op_e      : request opcode (WRITE, READ, POLL, reserved)
//   status_e  : response status (OK, TIMEOUT, ILLEGAL)
//   state_e   : master FSM states
//   bypass_addr() : register index to 16-bit byte address on the BRAM port
package bypass_reg_pkg;

    localparam int BYPASS_IDX_W      = 6;
    localparam int BYPASS_DATA_W     = 512;
    localparam int BYPASS_ADDR_SHIFT = 6;
    localparam int BYPASS_ADDR_W     = 16;
    // Indices below this are control registers, the rest are status registers.
    localparam int BYPASS_CTRL_REGS  = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ILLEGAL = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    function automatic logic [BYPASS_ADDR_W-1:0] bypass_addr(input logic [BYPASS_IDX_W-1:0] idx);
        return BYPASS_ADDR_W'(idx) << BYPASS_ADDR_SHIFT;
    endfunction

    function automatic logic is_status_idx(input logic [BYPASS_IDX_W-1:0] idx);
        return 32'(idx) >= BYPASS_CTRL_REGS;
    endfunction

endpackage

// File: rtl/dma_bypass_reg_master_if.sv
// dma_bypass_reg_master_if: request/response stream plus BRAM port of the bypass master.
//   s_req_*   : request stream (valid/ready, op, idx, data, mask)
//   m_rsp_*   : response stream (valid/ready, data, status)
//   bram_*_a  : 512-bit register-file port driven by the master
//   busy      : master not idle
// Modport master is the bypass master itself; slave is its environment.
interface dma_bypass_reg_master_if
    import bypass_reg_pkg::*;
;
    logic                      s_req_valid;
    logic                      s_req_ready;
    logic [1:0]                s_req_op;
    logic [BYPASS_IDX_W-1:0]   s_req_idx;
    logic [BYPASS_DATA_W-1:0]  s_req_data;
    logic [BYPASS_DATA_W-1:0]  s_req_mask;
    logic                      m_rsp_valid;
    logic                      m_rsp_ready;
    logic [BYPASS_DATA_W-1:0]  m_rsp_data;
    logic [1:0]                m_rsp_status;
    logic                      bram_en_a;
    logic                      bram_we_a;
    logic [BYPASS_ADDR_W-1:0]  bram_addr_a;
    logic [BYPASS_DATA_W-1:0]  bram_wrdata_a;
    logic [BYPASS_DATA_W-1:0]  bram_rddata_a;
    logic                      busy;

    modport master (
        input  s_req_valid, s_req_op, s_req_idx, s_req_data, s_req_mask,
        input  m_rsp_ready, bram_rddata_a,
        output s_req_ready, m_rsp_valid, m_rsp_data, m_rsp_status,
        output bram_en_a, bram_we_a, bram_addr_a, bram_wrdata_a, busy
    );

    modport slave (
        output s_req_valid, s_req_op, s_req_idx, s_req_data, s_req_mask,
        output m_rsp_ready, bram_rddata_a,
        input  s_req_ready, m_rsp_valid, m_rsp_data, m_rsp_status,
        input  bram_en_a, bram_we_a, bram_addr_a, bram_wrdata_a, busy
    );

endinterface

// File: rtl/dma_bypass_reg_master_poll_unit.sv
// bypass_poll_unit: masked compare and read counter for POLL requests.
//   user_clk, user_aresetn : clock, async active-low reset
//   clear : restart the read count (new request accepted)
//   inc   : one more mismatching read completed
//   rd, value, mask : read data, compare value, compare mask
//   match : (rd & mask) == (value & mask)
//   last  : the read being compared is read number POLL_MAX
module bypass_poll_unit
    import bypass_reg_pkg::*;
#(
    parameter int POLL_MAX = 1024
) (
    input  logic                     user_clk,
    input  logic                     user_aresetn,
    input  logic                     clear,
    input  logic                     inc,
    input  logic [BYPASS_DATA_W-1:0] rd,
    input  logic [BYPASS_DATA_W-1:0] value,
    input  logic [BYPASS_DATA_W-1:0] mask,
    output logic                     match,
    output logic                     last
);

    localparam int CNT_W = $clog2(POLL_MAX + 1);

    // Number of mismatching reads already completed for this request.
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match = ((rd ^ value) & mask) == '0;
    assign last  = cnt == CNT_W'(POLL_MAX - 1);

endmodule

// File: rtl/dma_bypass_reg_master.sv
// dma_bypass_reg_master: turns WRITE/READ/POLL requests into spaced accesses on the
// 512-bit bypass-register BRAM port and returns one response per request.
//   user_clk, user_aresetn : clock, async-assert active-low reset
//   bus (master modport)   : request stream, response stream, BRAM port, busy
// Build option: define BYPASS_POLL_EN to support POLL; otherwise op 2 is answered ILLEGAL.
module dma_bypass_reg_master
    import bypass_reg_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int ACCESS_GAP = 2,
    parameter int POLL_MAX   = 1024
) (
    input  logic                    user_clk,
    input  logic                    user_aresetn,
    dma_bypass_reg_master_if.master bus
);

    // Poll retries re-issue RD_LATENCY+1 cycles apart, so that spacing must honour ACCESS_GAP.
    if (RD_LATENCY < 1 || ACCESS_GAP < 1 || POLL_MAX < 1 || ACCESS_GAP > RD_LATENCY + 1) begin : g_bad_cfg
        $error("dma_bypass_reg_master: unsupported RD_LATENCY/ACCESS_GAP/POLL_MAX combination");
    end

    // The ISSUE cycle already counts toward the write gap, so WAIT covers the rest.
    localparam int WR_WAIT = (ACCESS_GAP > 2) ? ACCESS_GAP - 2 : 0;
    localparam int CNT_MAX = (RD_LATENCY > WR_WAIT) ? RD_LATENCY : WR_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e                   state, state_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    op_e                      op;
    status_e                  status_q;
    logic                     ready_q, en_q, we_q;
    logic [BYPASS_ADDR_W-1:0] addr_q;
    logic [BYPASS_DATA_W-1:0] wdata_q, rsp_data_q;
    logic                     accept, legal, wait_done, retry, timeout;

    assign accept    = bus.s_req_valid && ready_q;
    assign wait_done = state == S_WAIT && cnt == '0;

`ifdef BYPASS_POLL_EN
    logic [BYPASS_DATA_W-1:0] mask_q;
    logic                     poll_match, poll_last;

    assign legal   = bus.s_req_op != OP_RSVD;
    assign retry   = op == OP_POLL && !poll_match && !poll_last;
    assign timeout = op == OP_POLL && !poll_match && poll_last;

    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= bus.s_req_mask;
        end
    end

    // The poll compare value shares the write-data register.
    bypass_poll_unit #(.POLL_MAX(POLL_MAX)) u_poll (
        .user_clk     (user_clk),
        .user_aresetn (user_aresetn),
        .clear        (accept),
        .inc          (wait_done && retry),
        .rd           (bus.bram_rddata_a),
        .value        (wdata_q),
        .mask         (mask_q),
        .match        (poll_match),
        .last         (poll_last)
    );
`else
    assign legal   = bus.s_req_op == OP_WRITE || bus.s_req_op == OP_READ;
    assign retry   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE:  state_n = accept ? (legal ? S_ISSUE : S_RESP) : S_IDLE;
            S_ISSUE: begin
                state_n = (op == OP_WRITE && WR_WAIT == 0) ? S_RESP : S_WAIT;
                cnt_n   = CNT_W'(op == OP_WRITE ? WR_WAIT - 1 : RD_LATENCY - 1);
            end
            S_WAIT:  begin
                state_n = (cnt != '0) ? S_WAIT : (retry ? S_ISSUE : S_RESP);
                cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
            end
            S_RESP:  state_n = bus.m_rsp_ready ? S_IDLE : S_RESP;
            default: state_n = S_IDLE;
        endcase
    end

    // Port strobes and ready are registered from the next state so they are flop outputs.
    always_ff @(posedge user_clk or negedge user_aresetn) begin
        if (!user_aresetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op         <= OP_WRITE;
            status_q   <= ST_OK;
            ready_q    <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= state_n == S_IDLE;
            en_q    <= state_n == S_ISSUE;
            we_q    <= state == S_IDLE && state_n == S_ISSUE && bus.s_req_op == OP_WRITE;
            if (accept) begin
                op         <= op_e'(bus.s_req_op);
                addr_q     <= bypass_addr(bus.s_req_idx);
                wdata_q    <= bus.s_req_data;
                status_q   <= legal ? ST_OK : ST_ILLEGAL;
                rsp_data_q <= '0;
            end
            if (wait_done && op != OP_WRITE) begin
                rsp_data_q <= bus.bram_rddata_a;
            end
            if (wait_done && timeout) begin
                status_q <= ST_TIMEOUT;
            end
        end
    end

    assign bus.s_req_ready   = ready_q;
    assign bus.m_rsp_valid   = state == S_RESP;
    assign bus.m_rsp_data    = rsp_data_q;
    assign bus.m_rsp_status  = status_q;
    assign bus.bram_en_a     = en_q;
    assign bus.bram_we_a     = we_q;
    assign bus.bram_addr_a   = addr_q;
    assign bus.bram_wrdata_a = wdata_q;
    assign bus.busy          = state != S_IDLE;

endmodule

// File: tb/tb_dma_bypass_reg_master.sv
// tb_dma_bypass_reg_master: randomized self-checking bench with a request-level reference model.
module tb_dma_bypass_reg_master;
    import bypass_reg_pkg::*;

    localparam int RDL  = 2;
    localparam int PMAX = 4;
`ifdef BYPASS_POLL_EN
    localparam bit POLL_ON = 1'b1;
`else
    localparam bit POLL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_bypass_reg_master_if bus();

    dma_bypass_reg_master #(.RD_LATENCY(RDL), .ACCESS_GAP(2), .POLL_MAX(PMAX)) dut (
        .user_clk     (clk),
        .user_aresetn (rst_n),
        .bus          (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file behind the port, and the model's own view of it.
    logic [511:0] mem [64];
    logic [511:0] ref_mem [64];
    logic [511:0] script [$];
    logic [511:0] p1, nxt;

    always @(posedge clk) begin
        if (bus.bram_en_a && bus.bram_we_a) mem[bus.bram_addr_a[11:6]] <= bus.bram_wrdata_a;
        if (bus.bram_en_a && !bus.bram_we_a) begin
            nxt = (script.size() > 0) ? script.pop_front() : mem[bus.bram_addr_a[11:6]];
            p1 <= nxt;
        end
        bus.bram_rddata_a <= p1;
    end

    int           en_cyc [$];
    logic [15:0]  en_addr [$];
    logic         en_we [$];
    logic [511:0] en_wd [$];
    logic         prev_en = 1'b0;
    int           b2b = 0;

    always @(negedge clk) begin
        if (bus.bram_en_a) begin
            en_cyc.push_back(cyc);
            en_addr.push_back(bus.bram_addr_a);
            en_we.push_back(bus.bram_we_a);
            en_wd.push_back(bus.bram_wrdata_a);
            if (prev_en) b2b++;
        end
        prev_en = bus.bram_en_a;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Request-level reference: response data/status, number of port reads/writes, latency.
    function automatic void model(input logic [1:0] op, input logic [5:0] idx,
                                  input logic [511:0] data, input logic [511:0] mask,
                                  input logic [511:0] sc [$], output logic [511:0] d,
                                  output int st, output int n, output int lat);
        logic [511:0] v;
        d = '0; st = 0; n = 0; lat = 1;
        if (op == 2'd3 || (op == 2'd2 && !POLL_ON)) begin
            st = 2;
        end else if (op == 2'd0) begin
            ref_mem[idx] = data;
            n = 1; lat = 2;
        end else if (op == 2'd1) begin
            d = (sc.size() > 0) ? sc.pop_front() : ref_mem[idx];
            n = 1; lat = RDL + 2;
        end else begin
            st = 1;
            for (int k = 1; k <= PMAX; k++) begin
                v = (sc.size() > 0) ? sc.pop_front() : ref_mem[idx];
                d = v; n = k; lat = RDL + 2 + (RDL + 1) * (k - 1);
                if (((v ^ data) & mask) == '0) begin
                    st = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic run_req(input logic [1:0] op, input logic [5:0] idx, input logic [511:0] data,
                           input logic [511:0] mask, input bit rdy_rand, output int acc);
        logic [511:0] sc [$];
        logic [511:0] ed, fd;
        logic [1:0]   fs;
        int           es, en_n, el, rc;
        bit           stable, r;
        sc = script;
        model(op, idx, data, mask, sc, ed, es, en_n, el);
        acc = -1;
        en_cyc.delete(); en_addr.delete(); en_we.delete(); en_wd.delete();
        bus.s_req_valid = 1'b1;
        bus.s_req_op    = op;
        bus.s_req_idx   = idx;
        bus.s_req_data  = data;
        bus.s_req_mask  = mask;
        for (int i = 0; i < 50 && !bus.s_req_ready; i++) @(negedge clk);
        check("req_ready", bus.s_req_ready, 1);
        if (!bus.s_req_ready) begin
            bus.s_req_valid = 1'b0;
            script.delete();
            return;
        end
        acc = cyc;
        @(negedge clk);
        bus.s_req_valid = 1'b0;
        rc = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.m_rsp_valid) begin
                rc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", rc >= 0, 1);
        if (rc < 0) begin
            script.delete();
            return;
        end
        fd = bus.m_rsp_data;
        fs = bus.m_rsp_status;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            stable &= bus.m_rsp_valid && bus.m_rsp_data === fd && bus.m_rsp_status === fs;
            r = rdy_rand ? ($urandom % 3 == 0) : 1'b1;
            if (i == 99) r = 1'b1;
            bus.m_rsp_ready = r;
            @(negedge clk);
            if (r) break;
        end
        bus.m_rsp_ready = 1'b1;
        check("rsp_stable", stable, 1);
        check("rsp_data", fd, ed);
        check("rsp_status", fs, es);
        check("rsp_latency", rc - acc, el);
        check("ready_return", bus.s_req_ready, 1);
        check("rsp_drop", bus.m_rsp_valid, 0);
        check("en_count", en_cyc.size(), en_n);
        for (int j = 0; j < en_cyc.size(); j++) begin
            check("en_cycle", en_cyc[j] - acc, 1 + (RDL + 1) * j);
            check("en_addr", en_addr[j], {4'b0, idx, 6'b0});
            check("en_we", en_we[j], op == 2'd0);
            if (op == 2'd0) check("en_wrdata", en_wd[j], data);
        end
        script.delete();
    endtask

    task automatic check_outputs_zero();
        check("z_ready", bus.s_req_ready, 0);
        check("z_busy", bus.busy, 0);
        check("z_en", bus.bram_en_a, 0);
        check("z_we", bus.bram_we_a, 0);
        check("z_addr", bus.bram_addr_a, 0);
        check("z_wrdata", bus.bram_wrdata_a, 0);
        check("z_rsp_valid", bus.m_rsp_valid, 0);
        check("z_rsp_data", bus.m_rsp_data, 0);
        check("z_rsp_status", bus.m_rsp_status, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2, seen;
        logic [1:0] op;
        logic [511:0] d, m;
        bus.s_req_valid = 1'b0;
        bus.s_req_op    = '0;
        bus.s_req_idx   = '0;
        bus.s_req_data  = '0;
        bus.s_req_mask  = '0;
        bus.m_rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = rand512();
            ref_mem[i] = mem[i];
        end
        mem[34] = '0;
        ref_mem[34] = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        rst_n = 1'b1;
        @(negedge clk);

        run_req(2'd0, 6'd3, {64{8'hA5}}, '0, 1'b0, a1);
        run_req(2'd0, 6'd5, rand512(), '0, 1'b0, a2);
        check("wr_throughput", a2 - a1, 3);
        script.push_back(512'h1234);
        run_req(2'd1, 6'd40, '0, '0, 1'b0, a1);
        run_req(2'd1, 6'd3, '0, '0, 1'b0, a2);
        check("rd_throughput", a2 - a1, 5);
        script.push_back('0); script.push_back('0); script.push_back(512'h1);
        run_req(2'd2, 6'd33, 512'h1, 512'h1, 1'b0, a1);
        for (int i = 0; i < 4; i++) script.push_back('0);
        run_req(2'd2, 6'd34, 512'h1, 512'h1, 1'b0, a1);
        run_req(2'd3, 6'd7, rand512(), '0, 1'b0, a1);
        run_req(2'd2, 6'd9, rand512(), '0, 1'b0, a1);

        // Reset while a READ sits in WAIT.
        bus.s_req_valid = 1'b1;
        bus.s_req_op    = 2'd1;
        bus.s_req_idx   = 6'd40;
        bus.s_req_data  = rand512();
        for (int i = 0; i < 50 && !bus.s_req_ready; i++) @(negedge clk);
        @(negedge clk);
        bus.s_req_valid = 1'b0;
        @(negedge clk);
        check("rst_busy_before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero();
        @(negedge clk);
        @(negedge clk);
        en_cyc.delete();
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.m_rsp_valid) seen++;
        end
        check("rst_no_rsp", seen, 0);
        check("rst_no_en", en_cyc.size(), 0);
        script.push_back(512'hBEEF);
        run_req(2'd1, 6'd40, '0, '0, 1'b0, a1);

        for (int t = 0; t < 60; t++) begin
            op = 2'($urandom % 4);
            d  = rand512();
            m  = rand512();
            if (op == 2'd2) begin
                m = 512'h3;
                d = 512'($urandom % 4);
                for (int i = 0; i < $urandom % 6; i++) script.push_back(512'($urandom % 4));
            end else if (op == 2'd1 && $urandom % 2 == 0) begin
                script.push_back(rand512());
            end
            run_req(op, 6'($urandom % 64), d, m, 1'b1, a1);
            repeat ($urandom % 3) @(negedge clk);
        end
        check("en_spacing", b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
